anton_neopixel_apb: RTL and testbench
=====================================

Name: anton_neopixel_apb

Overview:
APB3 slave bridge placed directly upstream of the neopixel raw driver. It converts APB transfers into that driver's single-cycle bus strobes: busAddr, busDataIn, busWrite and busRead. It returns busDataOut as prdata. It decodes illegal addresses and, optionally, flags them with pslverr. Every transfer has fixed timing: setup + 2 access cycles.

Parameters:
PIXELS_MAX, 66, pixel buffer depth in bytes; must match the downstream driver.
APB_ADDR_BITS, 16, width of paddr; bits above 13 must be zero for a legal access.

Ports:
busClk  input  1  APB/bus clock, shared with the downstream driver's bus side.
busResetN  input  1  reset, asynchronous assert, active-low.
psel  input  1  APB select.
penable  input  1  APB enable (access phase).
pwrite  input  1  1 = write, 0 = read.
paddr  input  APB_ADDR_BITS  byte address.
pwdata  input  32  write data; only [7:0] used.
prdata  output  32  read data, {24'b0, byte}.
pready  output  1  transfer complete.
pslverr  output  1  transfer error.
busAddr  output  14  to driver, registered.
busDataIn  output  8  to driver, registered.
busWrite  output  1  to driver, one-cycle write strobe.
busRead  output  1  to driver, one-cycle read strobe.
busDataOut  input  8  from driver; registered read byte, valid the cycle after busRead.

Behaviour:
- Reset (busResetN=0, async): state=IDLE. busAddr=0, busDataIn=0, busWrite=0, busRead=0, pready=0, pslverr=0, prdata=0. Reset mid-transfer aborts with no further strobe. A strobe already sampled by the driver is not undone.
- FSM states: IDLE, STROBE, DONE.
- IDLE: on psel=1 & penable=0 (setup phase) at the clock edge:
  - register busAddr=paddr[13:0] and busDataIn=pwdata[7:0];
  - latch pwrite and the illegal flag;
  - go to STROBE.
  - penable=1 seen in IDLE without a prior setup is ignored.
- STROBE (first access cycle): busWrite=pwrite&!illegal and busRead=!pwrite&!illegal, each high for exactly this one cycle. pready=0. Next state: DONE.
- DONE (second access cycle): pready=1.
  - Read: prdata={24'b0,busDataOut} when legal, else 0.
  - pslverr=illegal, only with the optional feature.
  - Next state: IDLE.
  - Back-to-back transfers: the next setup cycle lands in IDLE, so throughput is 3 cycles per transfer.
- psel=0 in STROBE or DONE: abort to IDLE, pready stays 0, no second strobe.
- prdata and pslverr are 0 whenever pready=0.
- Address decode: illegal when any one of these holds:
  - paddr[APB_ADDR_BITS-1:14] != 0;
  - paddr[13]=0 and paddr[12:0] >= PIXELS_MAX;
  - paddr[13]=1 and paddr[12:2] != 0;
  - write to 0x2003 (status register, read-only).
- Legal register addresses: 0x2000 max_lo, 0x2001 max_hi, 0x2002 ctrl, 0x2003 status (read-only).
- Illegal accesses never strobe the driver. They keep identical 3-cycle timing.
- Address compare is unsigned, at full paddr width.

Optional Feature:
Macro ANTON_NEOPIXEL_APB_SLVERR_EN.
- Defined: pslverr=1 in DONE for illegal transfers; prdata=0.
- Undefined: pslverr is constant 0. Illegal writes are silently dropped and illegal reads return 0. Decode logic is still required to suppress strobes.

Test Plan:
1. Reset: hold busResetN=0 with psel toggling -> all outputs 0; release -> state IDLE, no strobes.
2. Write paddr=0x0005, pwdata=0xA5 -> STROBE cycle shows busAddr=0x0005, busDataIn=0xA5, busWrite=1 for exactly 1 cycle; pready=1 in the next cycle; pslverr=0.
3. Read paddr=0x2002 with the driver model returning 0x1C the cycle after busRead -> busRead=1 for 1 cycle; DONE shows prdata=0x0000001C, pready=1.
4. Back-to-back: write 0x0000, read 0x0000, write 0x0041 (PIXELS_MAX-1) -> 9 cycles total, exactly 3 strobes, read returns the byte just written.
5. Illegal accesses: write 0x0042, write 0x2003, read 0x2004, write 0x4000 -> no busWrite/busRead. With SLVERR_EN: pslverr=1 at pready. Without it: pslverr=0 and reads return 0.
6. Abort: drop psel in the STROBE cycle -> one strobe only, pready never asserted, FSM in IDLE and accepts the next setup. Also assert busResetN=0 in DONE -> pready falls immediately (async).

Source files
------------

// File: rtl/anton_neopixel_apb.sv
// ---------------------------------------------------------------------------
// anton_neopixel_apb
//
// APB3 slave front-end for the neopixel raw driver. Every APB transfer is
// turned into one single-cycle strobe (busWrite or busRead) on the driver's
// byte bus. The read byte comes back on busDataOut one cycle later and is
// returned as prdata. Transfer timing is fixed: setup + 2 access cycles
// (IDLE -> STROBE -> DONE).
//
// Address map (byte addresses, full paddr width, unsigned):
//   0x0000 .. PIXELS_MAX-1  pixel buffer (read/write)
//   0x2000 max_lo, 0x2001 max_hi, 0x2002 ctrl (read/write)
//   0x2003 status (read-only)
// Anything else is illegal. Illegal transfers never strobe the driver but
// keep the same 3-cycle timing.
//
// Optional feature macro: ANTON_NEOPIXEL_APB_SLVERR_EN
//   defined   : pslverr=1 in the completing cycle of an illegal transfer
//   undefined : pslverr tied to 0; illegal writes dropped, illegal reads = 0
//
// Parameters:
//   PIXELS_MAX     pixel buffer depth in bytes (< 8192), matches driver
//   APB_ADDR_BITS  paddr width (>= 14); bits above 13 must be zero
//
// Ports:
//   busClk      in   bus clock (shared with driver bus side)
//   busResetN   in   asynchronous active-low reset
//   psel        in   APB select
//   penable     in   APB access phase
//   pwrite      in   1 = write, 0 = read
//   paddr       in   byte address
//   pwdata      in   write data, [7:0] used
//   prdata      out  {24'b0, byte} in the completing cycle, else 0
//   pready      out  transfer complete
//   pslverr     out  transfer error
//   busAddr     out  registered driver address
//   busDataIn   out  registered driver write byte
//   busWrite    out  one-cycle driver write strobe
//   busRead     out  one-cycle driver read strobe
//   busDataOut  in   driver read byte, valid the cycle after busRead
// ---------------------------------------------------------------------------
module anton_neopixel_apb #(
  parameter int PIXELS_MAX    = 66,
  parameter int APB_ADDR_BITS = 16
) (
  input  logic                     busClk,
  input  logic                     busResetN,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [APB_ADDR_BITS-1:0] paddr,
  input  logic [31:0]              pwdata,
  output logic [31:0]              prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [13:0]              busAddr,
  output logic [7:0]               busDataIn,
  output logic                     busWrite,
  output logic                     busRead,
  input  logic [7:0]               busDataOut
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [12:0] PIX_LIM = 13'(PIXELS_MAX);

  state_t r_state;
  state_t w_state_next;
  logic   r_write;
  logic   r_illegal;

  logic   w_setup;
  logic   w_hi_bad;
  logic   w_pix_bad;
  logic   w_reg_bad;
  logic   w_ro_bad;
  logic   w_illegal;

  // Only the low byte of pwdata reaches the driver.
  logic   w_unused_pwdata;
  assign w_unused_pwdata = &{1'b0, pwdata[31:8]};

  // A setup phase is only accepted from IDLE; a bare penable is ignored.
  assign w_setup = (r_state == IDLE) && psel && !penable;

  // Address decode, evaluated on the setup cycle and latched with it.
  assign w_hi_bad  = (paddr >> 14) != '0;
  assign w_pix_bad = !paddr[13] && (paddr[12:0] >= PIX_LIM);
  assign w_reg_bad = paddr[13] && (paddr[12:2] != '0);
  assign w_ro_bad  = pwrite && (paddr[13:0] == 14'h2003);
  assign w_illegal = w_hi_bad || w_pix_bad || w_reg_bad || w_ro_bad;

  always_ff @(posedge busClk or negedge busResetN) begin
    if (!busResetN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge busClk or negedge busResetN) begin
    if (!busResetN) begin
      busAddr   <= '0;
      busDataIn <= '0;
      r_write   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_setup) begin
      busAddr   <= paddr[13:0];
      busDataIn <= pwdata[7:0];
      r_write   <= pwrite;
      r_illegal <= w_illegal;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busWrite     = 1'b0;
    busRead      = 1'b0;
    pready       = 1'b0;
    prdata       = '0;
    pslverr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_setup) w_state_next = STROBE;
      end
      STROBE: begin
        // The strobe fires even if psel drops here: the driver has already
        // been addressed and cannot be held off.
        busWrite     = r_write && !r_illegal;
        busRead      = !r_write && !r_illegal;
        w_state_next = psel ? DONE : IDLE;
      end
      DONE: begin
        // pready follows psel so a dropped select completes nothing.
        pready = psel;
        if (psel && !r_write && !r_illegal) prdata = {24'b0, busDataOut};
`ifdef ANTON_NEOPIXEL_APB_SLVERR_EN
        pslverr = psel && r_illegal;
`endif
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_anton_neopixel_apb.sv
module tb_anton_neopixel_apb;

  localparam int PIXELS_MAX    = 66;
  localparam int APB_ADDR_BITS = 16;
  localparam int MEM_DEPTH     = PIXELS_MAX + 4;

  logic        busClk = 1'b0;
  logic        busResetN = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [13:0] busAddr;
  logic [7:0]  busDataIn;
  logic        busWrite;
  logic        busRead;
  logic [7:0]  busDataOut = '0;

  anton_neopixel_apb #(
    .PIXELS_MAX   (PIXELS_MAX),
    .APB_ADDR_BITS(APB_ADDR_BITS)
  ) dut (
    .busClk    (busClk),
    .busResetN (busResetN),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .busAddr   (busAddr),
    .busDataIn (busDataIn),
    .busWrite  (busWrite),
    .busRead   (busRead),
    .busDataOut(busDataOut)
  );

  always #5 busClk = ~busClk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int n_wr  = 0;
  int n_rd  = 0;

  // Downstream driver model memory and the independent reference copy.
  logic [7:0] drv_mem [MEM_DEPTH];
  logic [7:0] ref_mem [MEM_DEPTH];

  function automatic int mem_idx(input logic [13:0] a);
    if (a[13]) return PIXELS_MAX + int'(a[1:0]);
    return int'(a[12:0]);
  endfunction

  // Legality straight from the address map.
  function automatic bit is_legal(input logic [15:0] a, input bit wr);
    int ai = int'(a);
    if (ai >= 16384) return 0;
    if (ai < 8192)   return ai < PIXELS_MAX;
    if (ai - 8192 >= 4) return 0;
    if (wr && ai == 'h2003) return 0;
    return 1;
  endfunction

  // Driver model: registered byte bus.
  always @(posedge busClk) begin
    cyc <= cyc + 1;
    if (busWrite) begin
      n_wr <= n_wr + 1;
      drv_mem[mem_idx(busAddr)] <= busDataIn;
    end
    if (busRead) begin
      n_rd <= n_rd + 1;
      busDataOut <= drv_mem[mem_idx(busAddr)];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full APB transfer; starts and ends just after a rising edge.
  task automatic apb_xfer(input bit wr, input logic [15:0] addr, input logic [7:0] data,
                          input bit idle_after);
    bit          lg = is_legal(addr, wr);
    int          w0 = n_wr;
    int          r0 = n_rd;
    logic [31:0] tmp = $urandom();
    logic [31:0] exp_rd;
    bit          exp_err;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = {tmp[31:8], data};
    @(posedge busClk); #1;
    penable = 1'b1;
    @(negedge busClk);
    chk("strobe_pready", {31'b0, pready}, 32'd0);
    chk("strobe_wr", {31'b0, busWrite}, {31'b0, wr && lg});
    chk("strobe_rd", {31'b0, busRead}, {31'b0, !wr && lg});
    if (lg) chk("strobe_addr", {18'b0, busAddr}, {18'b0, addr[13:0]});
    if (lg && wr) chk("strobe_data", {24'b0, busDataIn}, {24'b0, data});
    @(posedge busClk); #1;
    @(negedge busClk);
    exp_rd = (!wr && lg) ? {24'b0, ref_mem[mem_idx(addr[13:0])]} : 32'd0;
`ifdef ANTON_NEOPIXEL_APB_SLVERR_EN
    exp_err = !lg;
`else
    exp_err = 1'b0;
`endif
    chk("done_pready", {31'b0, pready}, 32'd1);
    chk("done_prdata", prdata, exp_rd);
    chk("done_pslverr", {31'b0, pslverr}, {31'b0, exp_err});
    chk("n_wr_strobes", n_wr - w0, (wr && lg) ? 1 : 0);
    chk("n_rd_strobes", n_rd - r0, (!wr && lg) ? 1 : 0);
    $display("xfer %s addr=%h data=%h legal=%0d prdata=%h pslverr=%0d",
             wr ? "WR" : "RD", addr, data, lg, prdata, pslverr);
    if (wr && lg) ref_mem[mem_idx(addr[13:0])] = data;
    @(posedge busClk); #1;
    penable = 1'b0;
    if (idle_after) psel = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pready"}, {31'b0, pready}, 32'd0);
    chk({tag, "_pslverr"}, {31'b0, pslverr}, 32'd0);
    chk({tag, "_prdata"}, prdata, 32'd0);
    chk({tag, "_busWrite"}, {31'b0, busWrite}, 32'd0);
    chk({tag, "_busRead"}, {31'b0, busRead}, 32'd0);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1: return 16'($urandom_range(0, PIXELS_MAX - 1));
      2:    return 16'($urandom_range(PIXELS_MAX, PIXELS_MAX + 8));
      3:    return 16'($urandom_range('h2000, 'h2003));
      4:    return 16'($urandom_range('h2004, 'h2010));
      default: return 16'($urandom_range('h4000, 'hFFFF));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int w0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      drv_mem[i] = 8'(i * 3 + 1);
      ref_mem[i] = 8'(i * 3 + 1);
    end
    // Driver's ctrl register reads back 0x1C.
    drv_mem[PIXELS_MAX + 2] = 8'h1C;
    ref_mem[PIXELS_MAX + 2] = 8'h1C;

    // Reset held with psel activity.
    for (int i = 0; i < 4; i++) begin
      psel = i[0]; penable = i[1]; paddr = 16'h0005;
      @(negedge busClk);
      chk_idle_outputs("rst");
      chk("rst_busAddr", {18'b0, busAddr}, 32'd0);
      chk("rst_busDataIn", {24'b0, busDataIn}, 32'd0);
    end
    psel = 1'b0; penable = 1'b0;
    busResetN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge busClk);
      chk_idle_outputs("post_rst");
    end
    @(posedge busClk); #1;

    // Bare penable in IDLE is ignored.
    w0 = n_wr + n_rd;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'h0003;
    repeat (3) begin
      @(negedge busClk);
      chk_idle_outputs("no_setup");
    end
    @(posedge busClk); #1;
    chk("no_setup_strobes", n_wr + n_rd - w0, 0);
    psel = 1'b0; penable = 1'b0;
    @(posedge busClk); #1;

    // Directed legal transfers.
    apb_xfer(1'b1, 16'h0005, 8'hA5, 1'b1);
    apb_xfer(1'b0, 16'h2002, 8'h00, 1'b1);

    // Back-to-back: 9 cycles, 3 strobes, read returns the byte just written.
    t0 = cyc;
    w0 = n_wr + n_rd;
    apb_xfer(1'b1, 16'h0000, 8'h5A, 1'b0);
    apb_xfer(1'b0, 16'h0000, 8'h00, 1'b0);
    apb_xfer(1'b1, 16'h0041, 8'hC3, 1'b1);
    chk("b2b_cycles", cyc - t0, 9);
    chk("b2b_strobes", n_wr + n_rd - w0, 3);

    // Illegal accesses.
    apb_xfer(1'b1, 16'h0042, 8'h11, 1'b1);
    apb_xfer(1'b1, 16'h2003, 8'h22, 1'b1);
    apb_xfer(1'b0, 16'h2004, 8'h00, 1'b1);
    apb_xfer(1'b1, 16'h4000, 8'h33, 1'b1);
    apb_xfer(1'b0, 16'h0042, 8'h00, 1'b1);
    apb_xfer(1'b0, 16'h2003, 8'h00, 1'b1);

    // Abort by dropping psel in the strobe cycle.
    w0 = n_wr;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0007; pwdata = 32'h0000003C;
    @(posedge busClk); #1;
    psel = 1'b0;
    @(negedge busClk);
    chk("abort_strobe", {31'b0, busWrite}, 32'd1);
    repeat (3) begin
      @(negedge busClk);
      chk_idle_outputs("abort");
    end
    @(posedge busClk); #1;
    chk("abort_strobes", n_wr - w0, 1);
    ref_mem[7] = 8'h3C;
    apb_xfer(1'b0, 16'h0007, 8'h00, 1'b1);

    // Asynchronous reset in the completing cycle.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0001;
    @(posedge busClk); #1;
    penable = 1'b1;
    @(posedge busClk); #1;
    @(negedge busClk);
    chk("rst_done_pready_before", {31'b0, pready}, 32'd1);
    #1 busResetN = 1'b0;
    #1;
    chk("rst_done_pready_after", {31'b0, pready}, 32'd0);
    chk("rst_done_prdata_after", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge busClk);
    busResetN = 1'b1;
    @(posedge busClk); #1;
    apb_xfer(1'b0, 16'h0001, 8'h00, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      logic [15:0] a = rand_addr();
      bit          wr = 1'($urandom_range(0, 1));
      logic [7:0]  d = 8'($urandom());
      apb_xfer(wr, a, d, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
